// File: rtl/regfile_rdport_arbiter.sv
// regfile_rdport_arbiter
// Purpose: shares READPORT_NUM synchronous regfile read ports among REQ_NUM
// issue-side requesters. Each requester needs up to NUMSRCS operands. The
// regfile returns read data one cycle later, and this block routes that data
// back to the requester and source slot that asked for it.
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   i_flush                  pipeline squash: no grants and no responses this cycle
//   i_req / i_req_idx        per-requester request and physical source indices
//   o_grant                  combinational all-or-nothing grant per requester
//   o_read_idx               regfile read index per port, 0 when the port is unused
//   i_read_data/i_data_rdy   regfile return for the indices driven last cycle
//   o_resp_vld/_data/_rdy    operands for the grants made last cycle

module regfile_rdport_arbiter #(
    parameter int unsigned REQ_NUM      = 4,
    parameter int unsigned NUMSRCS      = 2,
    parameter int unsigned READPORT_NUM = 6,
    parameter int unsigned SIZE         = 80,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned XLEN         = 64,
    localparam int unsigned IDXW        = $clog2(SIZE)
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      i_flush,
    input  logic [REQ_NUM-1:0]                        i_req,
    input  logic [REQ_NUM-1:0][NUMSRCS-1:0][IDXW-1:0] i_req_idx,
    output logic [REQ_NUM-1:0]                        o_grant,
    output logic [READPORT_NUM-1:0][IDXW-1:0]         o_read_idx,
    input  logic [READPORT_NUM-1:0][XLEN-1:0]         i_read_data,
    input  logic [READPORT_NUM-1:0]                   i_data_rdy,
    output logic [REQ_NUM-1:0]                        o_resp_vld,
    output logic [REQ_NUM-1:0][NUMSRCS-1:0][XLEN-1:0] o_resp_data,
    output logic [REQ_NUM-1:0][NUMSRCS-1:0]           o_resp_rdy
);

    localparam int unsigned PTRW  = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
    localparam int unsigned PORTW = (READPORT_NUM > 1) ? $clog2(READPORT_NUM) : 1;
    localparam int unsigned CNTW  = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNTW-1:0] STARVE_MAX = CNTW'(STARVE_LIMIT);

    // Registered state
    logic [PTRW-1:0]                            ptr_q, ptr_d;
    logic [REQ_NUM-1:0][CNTW-1:0]               starve_q, starve_d;
    logic [REQ_NUM-1:0]                         resp_vld_q, resp_vld_d;
    logic [REQ_NUM-1:0][NUMSRCS-1:0][PORTW-1:0] resp_port_q, resp_port_d;
    logic [REQ_NUM-1:0][NUMSRCS-1:0]            resp_zero_q, resp_zero_d;

    // Arbitration results
    logic                              arb_en_c;
    logic [REQ_NUM-1:0]                starving_c;
    logic [REQ_NUM-1:0]                grant_c;
    logic [READPORT_NUM-1:0][IDXW-1:0] read_idx_c;
    logic                              last_vld_c;
    logic [PTRW-1:0]                   last_req_c;
    int unsigned                       need_c [REQ_NUM];
    int unsigned                       ports_used_c;
    int unsigned                       port_claims_c [READPORT_NUM];

    // Port need per requester: index 0 is the zero register and needs no port
    always_comb begin
        for (int unsigned r = 0; r < REQ_NUM; r++) begin
            need_c[r] = 0;
            for (int unsigned s = 0; s < NUMSRCS; s++) begin
                if (i_req_idx[r][s] != '0) begin
                    need_c[r] = need_c[r] + 1;
                end
            end
            starving_c[r] = (starve_q[r] == STARVE_MAX);
        end
    end

    // Priority walk. The first REQ_NUM slots visit starving requesters in
    // index order. The next REQ_NUM slots visit the remaining requesters in
    // rotation from ptr. Each grant takes the lowest free ports in order.
    always_comb begin
        int unsigned r;
        int unsigned free_ports;
        logic        cand;

        arb_en_c     = ~rst & ~i_flush;
        grant_c      = '0;
        read_idx_c   = '0;
        resp_port_d  = '0;
        resp_zero_d  = '0;
        last_vld_c   = 1'b0;
        last_req_c   = '0;
        ports_used_c = 0;
        for (int unsigned p = 0; p < READPORT_NUM; p++) begin
            port_claims_c[p] = 0;
        end
        r          = 0;
        free_ports = READPORT_NUM;
        cand       = 1'b0;

        for (int unsigned i = 0; i < 2 * REQ_NUM; i++) begin
            if (i < REQ_NUM) begin
                r    = i;
                cand = starving_c[PTRW'(r)];
            end else begin
                r = 32'(ptr_q) + (i - REQ_NUM);
                if (r >= REQ_NUM) begin
                    r = r - REQ_NUM;
                end
                cand = ~starving_c[PTRW'(r)];
            end

            if (arb_en_c && cand && i_req[PTRW'(r)] && (need_c[PTRW'(r)] <= free_ports)) begin
                grant_c[PTRW'(r)] = 1'b1;
                last_vld_c        = 1'b1;
                last_req_c        = PTRW'(r);
                for (int unsigned s = 0; s < NUMSRCS; s++) begin
                    if (i_req_idx[PTRW'(r)][s] != '0) begin
                        read_idx_c[PORTW'(ports_used_c)]    = i_req_idx[PTRW'(r)][s];
                        resp_port_d[PTRW'(r)][s]            = PORTW'(ports_used_c);
                        port_claims_c[PORTW'(ports_used_c)] = port_claims_c[PORTW'(ports_used_c)] + 1;
                        ports_used_c                        = ports_used_c + 1;
                    end else begin
                        resp_zero_d[PTRW'(r)][s] = 1'b1;
                    end
                end
                free_ports = free_ports - need_c[PTRW'(r)];
            end
        end
    end

    // Rotation pointer and starvation counters. Both hold during flush.
    always_comb begin
        ptr_d      = ptr_q;
        starve_d   = starve_q;
        resp_vld_d = grant_c;
        if (arb_en_c) begin
            if (last_vld_c) begin
                ptr_d = (32'(last_req_c) == REQ_NUM - 1) ? '0 : last_req_c + 1'b1;
            end
            for (int unsigned r = 0; r < REQ_NUM; r++) begin
                if (i_req[r] && !grant_c[r]) begin
                    starve_d[r] = starving_c[r] ? starve_q[r] : starve_q[r] + 1'b1;
                end else begin
                    starve_d[r] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            starve_q    <= '0;
            resp_vld_q  <= '0;
            resp_port_q <= '0;
            resp_zero_q <= '0;
        end else begin
            ptr_q       <= ptr_d;
            starve_q    <= starve_d;
            resp_vld_q  <= resp_vld_d;
            resp_port_q <= resp_port_d;
            resp_zero_q <= resp_zero_d;
        end
    end

    assign o_grant    = grant_c;
    assign o_read_idx = read_idx_c;

    // Response mux: a zero-register source returns data 0 with rdy 1
    always_comb begin
        o_resp_vld  = resp_vld_q & {REQ_NUM{~(rst | i_flush)}};
        o_resp_data = '0;
        o_resp_rdy  = '0;
        for (int unsigned r = 0; r < REQ_NUM; r++) begin
            for (int unsigned s = 0; s < NUMSRCS; s++) begin
                if (o_resp_vld[r]) begin
                    if (resp_zero_q[r][s]) begin
                        o_resp_rdy[r][s] = 1'b1;
                    end else begin
                        o_resp_data[r][s] = i_read_data[resp_port_q[r][s]];
                        o_resp_rdy[r][s]  = i_data_rdy[resp_port_q[r][s]];
                    end
                end
            end
        end
    end

    // Sanity: never hand out more ports than exist, never share a port
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (ports_used_c <= READPORT_NUM);
            for (int unsigned p = 0; p < READPORT_NUM; p++) begin
                assert (port_claims_c[p] <= 1);
            end
        end
    end

endmodule

// File: tb/tb_regfile_rdport_arbiter.sv
// Testbench for regfile_rdport_arbiter. The DUT has 4 requesters, 4 ports
// and a starvation limit of 2. A priority-list model predicts every cycle,
// and directed literal checks confirm specific cycles.

module tb_regfile_rdport_arbiter;

    localparam int unsigned REQ   = 4;
    localparam int unsigned NS    = 2;
    localparam int unsigned PORTS = 4;
    localparam int unsigned SIZE  = 80;
    localparam int unsigned LIMIT = 2;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned IDXW  = $clog2(SIZE);

    logic                               clk;
    logic                               rst;
    logic                               i_flush;
    logic [REQ-1:0]                     i_req;
    logic [REQ-1:0][NS-1:0][IDXW-1:0]   i_req_idx;
    logic [REQ-1:0]                     o_grant;
    logic [PORTS-1:0][IDXW-1:0]         o_read_idx;
    logic [PORTS-1:0][XLEN-1:0]         i_read_data;
    logic [PORTS-1:0]                   i_data_rdy;
    logic [REQ-1:0]                     o_resp_vld;
    logic [REQ-1:0][NS-1:0][XLEN-1:0]   o_resp_data;
    logic [REQ-1:0][NS-1:0]             o_resp_rdy;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state (committed on posedge) and next-state (computed on negedge)
    int m_ptr;
    int m_starve [REQ];
    bit m_rv     [REQ];
    int m_rport  [REQ][NS];
    bit m_rzero  [REQ][NS];
    int n_ptr;
    int n_starve [REQ];
    bit n_rv     [REQ];
    int n_rport  [REQ][NS];
    bit n_rzero  [REQ][NS];

    logic [REQ-1:0]                   e_grant;
    logic [PORTS-1:0][IDXW-1:0]       e_read_idx;
    logic [REQ-1:0]                   e_resp_vld;
    logic [REQ-1:0][NS-1:0][XLEN-1:0] e_resp_data;
    logic [REQ-1:0][NS-1:0]           e_resp_rdy;

    regfile_rdport_arbiter #(
        .REQ_NUM     (REQ),
        .NUMSRCS     (NS),
        .READPORT_NUM(PORTS),
        .SIZE        (SIZE),
        .STARVE_LIMIT(LIMIT),
        .XLEN        (XLEN)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .i_flush    (i_flush),
        .i_req      (i_req),
        .i_req_idx  (i_req_idx),
        .o_grant    (o_grant),
        .o_read_idx (o_read_idx),
        .i_read_data(i_read_data),
        .i_data_rdy (i_data_rdy),
        .o_resp_vld (o_resp_vld),
        .o_resp_data(o_resp_data),
        .o_resp_rdy (o_resp_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Build the priority list, then hand out ports in list order
    function automatic void model_eval();
        int order[$];
        int free_ports;
        int nxt;
        int need;
        int r;
        e_grant    = '0;
        e_read_idx = '0;
        n_ptr      = m_ptr;
        for (int q = 0; q < REQ; q++) begin
            n_starve[q] = m_starve[q];
            n_rv[q]     = 1'b0;
            for (int s = 0; s < NS; s++) begin
                n_rport[q][s] = 0;
                n_rzero[q][s] = 1'b0;
            end
        end
        if (!rst && !i_flush) begin
            for (int k = 0; k < REQ; k++)
                if (m_starve[k] == LIMIT) order.push_back(k);
            for (int k = 0; k < REQ; k++) begin
                r = (m_ptr + k) % REQ;
                if (m_starve[r] != LIMIT) order.push_back(r);
            end
            free_ports = PORTS;
            nxt        = 0;
            foreach (order[j]) begin
                r    = order[j];
                need = 0;
                for (int s = 0; s < NS; s++)
                    if (i_req_idx[r][s] != 0) need++;
                if (i_req[r] && need <= free_ports) begin
                    e_grant[r] = 1'b1;
                    n_rv[r]    = 1'b1;
                    for (int s = 0; s < NS; s++) begin
                        if (i_req_idx[r][s] != 0) begin
                            e_read_idx[nxt] = i_req_idx[r][s];
                            n_rport[r][s]   = nxt;
                            nxt++;
                        end else begin
                            n_rzero[r][s] = 1'b1;
                        end
                    end
                    free_ports -= need;
                    n_ptr = (r + 1) % REQ;
                end
            end
            for (int q = 0; q < REQ; q++) begin
                if (i_req[q] && !e_grant[q])
                    n_starve[q] = (m_starve[q] + 1 > LIMIT) ? LIMIT : m_starve[q] + 1;
                else
                    n_starve[q] = 0;
            end
        end
        e_resp_vld  = '0;
        e_resp_data = '0;
        e_resp_rdy  = '0;
        for (int q = 0; q < REQ; q++) begin
            if (m_rv[q] && !i_flush && !rst) begin
                e_resp_vld[q] = 1'b1;
                for (int s = 0; s < NS; s++) begin
                    if (m_rzero[q][s]) begin
                        e_resp_rdy[q][s] = 1'b1;
                    end else begin
                        e_resp_data[q][s] = i_read_data[m_rport[q][s]];
                        e_resp_rdy[q][s]  = i_data_rdy[m_rport[q][s]];
                    end
                end
            end
        end
    endfunction

    // Compare process: inputs are stable at the falling edge
    always @(negedge clk) begin
        model_eval();
        check("grant",     256'(o_grant),     256'(e_grant));
        check("read_idx",  256'(o_read_idx),  256'(e_read_idx));
        check("resp_vld",  256'(o_resp_vld),  256'(e_resp_vld));
        check("resp_data", 256'(o_resp_data), 256'(e_resp_data));
        check("resp_rdy",  256'(o_resp_rdy),  256'(e_resp_rdy));
    end

    // Model commit on the same edge the DUT samples
    always @(posedge clk) begin
        if (rst) begin
            m_ptr = 0;
            for (int q = 0; q < REQ; q++) begin
                m_starve[q] = 0;
                m_rv[q]     = 1'b0;
            end
        end else begin
            m_ptr = n_ptr;
            for (int q = 0; q < REQ; q++) begin
                m_starve[q] = n_starve[q];
                m_rv[q]     = n_rv[q];
                for (int s = 0; s < NS; s++) begin
                    m_rport[q][s] = n_rport[q][s];
                    m_rzero[q][s] = n_rzero[q][s];
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int tag);
        for (int p = 0; p < PORTS; p++)
            i_read_data[p] = 32'hD000_0000 + 32'(tag * 16 + p);
        i_data_rdy = '1;
    endtask

    task automatic set_req(input logic [REQ-1:0] rq, input int a0, input int b0, input int a1,
                           input int b1, input int a2, input int b2, input int a3, input int b3);
        i_req           = rq;
        i_req_idx[0][0] = IDXW'(a0);
        i_req_idx[0][1] = IDXW'(b0);
        i_req_idx[1][0] = IDXW'(a1);
        i_req_idx[1][1] = IDXW'(b1);
        i_req_idx[2][0] = IDXW'(a2);
        i_req_idx[2][1] = IDXW'(b2);
        i_req_idx[3][0] = IDXW'(a3);
        i_req_idx[3][1] = IDXW'(b3);
    endtask

    initial begin
        rst     = 1'b1;
        i_flush = 1'b0;
        set_req(4'b1111, 1, 2, 3, 4, 5, 6, 7, 8);
        set_rd(0);
        cyc();
        #1;
        check("rst_grant",    256'(o_grant),    256'(0));
        check("rst_read_idx", 256'(o_read_idx), 256'(0));
        check("rst_resp_vld", 256'(o_resp_vld), 256'(0));
        cyc();

        // A: three requesters need 2 ports each and only 4 ports exist
        rst = 1'b0;
        set_req(4'b0111, 5, 6, 7, 8, 9, 10, 0, 0);
        set_rd(1);
        #1;
        check("A_grant", 256'(o_grant), 256'(4'b0011));
        check("A_read_idx", 256'(o_read_idx), 256'({7'd8, 7'd7, 7'd6, 7'd5}));
        cyc();
        // B: rotation starts at r2
        set_rd(2);
        #1;
        check("B_grant", 256'(o_grant), 256'(4'b0101));
        check("B_read_idx", 256'(o_read_idx), 256'({7'd6, 7'd5, 7'd10, 7'd9}));
        check("B_resp_vld", 256'(o_resp_vld), 256'(4'b0011));
        check("B_resp_r1s1", 256'(o_resp_data[1][1]), 256'(32'hD000_0023));
        cyc();
        // C: ptr=1
        set_rd(3);
        #1;
        check("C_grant", 256'(o_grant), 256'(4'b0110));
        cyc();

        // D/E: zero-register source
        set_req(4'b0001, 0, 12, 0, 0, 0, 0, 0, 0);
        set_rd(4);
        #1;
        check("D_grant", 256'(o_grant), 256'(4'b0001));
        check("D_read_idx", 256'(o_read_idx), 256'({7'd0, 7'd0, 7'd0, 7'd12}));
        cyc();
        set_req(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0);
        set_rd(5);
        i_read_data[0] = 32'h0000_ABCD;
        i_data_rdy     = 4'b1110;
        #1;
        check("E_resp_vld", 256'(o_resp_vld), 256'(4'b0001));
        check("E_resp_data0", 256'(o_resp_data[0]), 256'({32'h0000_ABCD, 32'h0}));
        check("E_resp_rdy0", 256'(o_resp_rdy[0]), 256'(2'b01));
        cyc();

        // F..J: r2 cannot fit at first, later 1-port requests still fit, and r2 is promoted at the limit
        set_req(4'b1111, 1, 2, 3, 0, 4, 5, 0, 6);
        set_rd(6);
        #1;
        check("F_grant", 256'(o_grant), 256'(4'b1110));
        cyc();
        set_rd(7);
        #1;
        check("G_grant", 256'(o_grant), 256'(4'b1011));
        check("G_read_idx", 256'(o_read_idx), 256'({7'd6, 7'd3, 7'd2, 7'd1}));
        cyc();
        set_rd(8);
        #1;
        check("H_grant", 256'(o_grant), 256'(4'b1011));
        cyc();
        set_rd(9);
        #1;
        check("I_grant_starved", 256'(o_grant), 256'(4'b0101));
        check("I_read_idx", 256'(o_read_idx), 256'({7'd2, 7'd1, 7'd5, 7'd4}));
        cyc();
        set_rd(10);
        #1;
        check("J_resp_vld", 256'(o_resp_vld), 256'(4'b0101));
        check("J_resp_r2", 256'(o_resp_data[2]), 256'({32'hD000_00A1, 32'hD000_00A0}));
        cyc();

        // K..M: flush holds state and suppresses grants and responses
        set_rd(11);
        #1;
        check("K_grant", 256'(o_grant), 256'(4'b1011));
        cyc();
        i_flush = 1'b1;
        set_rd(12);
        #1;
        check("L_grant_flush", 256'(o_grant), 256'(0));
        check("L_read_idx_flush", 256'(o_read_idx), 256'(0));
        check("L_resp_vld_flush", 256'(o_resp_vld), 256'(0));
        cyc();
        i_flush = 1'b0;
        set_rd(13);
        #1;
        check("M_grant", 256'(o_grant), 256'(4'b1011));
        check("M_resp_vld", 256'(o_resp_vld), 256'(0));
        cyc();

        // N..P: reset right after a grant
        set_rd(14);
        #1;
        check("N_grant", 256'(o_grant), 256'(4'b0101));
        cyc();
        rst = 1'b1;
        set_rd(15);
        #1;
        check("O_grant_rst", 256'(o_grant), 256'(0));
        check("O_resp_vld_rst", 256'(o_resp_vld), 256'(0));
        cyc();
        rst = 1'b0;
        set_req(4'b1111, 1, 2, 3, 4, 5, 6, 7, 8);
        set_rd(16);
        #1;
        check("P_grant", 256'(o_grant), 256'(4'b0011));
        check("P_read_idx", 256'(o_read_idx), 256'({7'd4, 7'd3, 7'd2, 7'd1}));
        check("P_resp_vld", 256'(o_resp_vld), 256'(0));
        cyc();

        // Q/R: a need-0 requester is granted without using a port
        set_req(4'b1111, 0, 0, 1, 2, 3, 4, 5, 6);
        set_rd(17);
        #1;
        check("Q_grant", 256'(o_grant), 256'(4'b1101));
        cyc();
        set_req(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0);
        set_rd(18);
        #1;
        check("R_resp_vld", 256'(o_resp_vld), 256'(4'b1101));
        check("R_resp_rdy0", 256'(o_resp_rdy[0]), 256'(2'b11));
        check("R_resp_data0", 256'(o_resp_data[0]), 256'(0));
        cyc();

        // Mixed traffic checked by the model alone
        for (int c = 0; c < 60; c++) begin
            i_req = REQ'($urandom);
            for (int q = 0; q < REQ; q++)
                for (int s = 0; s < NS; s++)
                    i_req_idx[q][s] = ($urandom_range(0, 2) == 0) ? '0 : IDXW'($urandom_range(1, SIZE - 1));
            for (int p = 0; p < PORTS; p++)
                i_read_data[p] = $urandom;
            i_data_rdy = PORTS'($urandom);
            i_flush    = ($urandom_range(0, 7) == 0);
            rst        = ($urandom_range(0, 19) == 0);
            cyc();
        end
        rst     = 1'b0;
        i_flush = 1'b0;
        i_req   = '0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
